load_store_unit: RTL and testbench

- Initiator side of the MIPS data-memory interface. It sits between the datapath and the data memory.
- Accepts one load/store request per transaction from the core and handles address alignment and range checks.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Drives the data memory's Address, WriteData, MemWrite and MemRead, and consumes its combinational ReadData.

---
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MIPS data-memory initiator: takes one load/store from the core, checks alignment
// and range, does read-modify-write for sub-word stores and extends load data.
module load_store_unit #(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          MEMORY_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  addr_error,
    output logic [31:0]           mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [1:0]            dbgState
);

    // Handshake: a request transfers on a rising clk edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, so the core must
    // hold its request until then. resp_valid is a single-cycle pulse, no back-pressure.

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // 33-bit limit so a segment ending at the top of the address space cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEMORY_DEPTH);

    logic [1:0]            state;
    logic [1:0]            nextState;
    logic                  reqWrite;
    logic [1:0]            reqSize;
    logic                  reqSigned;
    logic [31:0]           reqAddr;
    logic [DATA_WIDTH-1:0] reqWdata;
    logic                  errFlag;
    logic [DATA_WIDTH-1:0] rdWord;

    logic                  isMisaligned;
    logic                  isIllegal;
    logic                  isOutOfRange;
    logic                  reqError;
    logic                  accept;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [DATA_WIDTH-1:0] loadData;
    logic [7:0]            byteLane;
    logic [15:0]           halfLane;

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        isIllegal    = (req_size == SIZE_BAD);
        isMisaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                       ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
        isOutOfRange = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= ADDR_LIMIT);
        reqError     = isIllegal || isMisaligned || isOutOfRange;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reqError) begin
                        nextState = RESP;
                    end else if (!req_write || (req_size != SIZE_WORD)) begin
                        nextState = READ;
                    end else begin
                        nextState = WRITE;
                    end
                end
            end
            READ:    nextState = reqWrite ? WRITE : RESP;
            WRITE:   nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            reqWrite  <= 1'b0;
            reqSize   <= 2'b00;
            reqSigned <= 1'b0;
            reqAddr   <= '0;
            reqWdata  <= '0;
            errFlag   <= 1'b0;
            rdWord    <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                reqWrite  <= req_write;
                reqSize   <= req_size;
                reqSigned <= req_signed;
                reqAddr   <= req_addr;
                reqWdata  <= req_wdata;
                errFlag   <= reqError;
            end
            if (state == READ) begin
                rdWord <= mem_read_data;
            end
        end
    end

    // Little-endian lanes: byte n occupies bits [8n+7:8n].
    always_comb begin
        mergedWord = rdWord;
        case (reqSize)
            SIZE_BYTE: mergedWord[{reqAddr[1:0], 3'b000} +: 8]  = reqWdata[7:0];
            SIZE_HALF: mergedWord[{reqAddr[1], 4'b0000} +: 16]  = reqWdata[15:0];
            default:   mergedWord = reqWdata;
        endcase
    end

    always_comb begin
        byteLane = rdWord[{reqAddr[1:0], 3'b000} +: 8];
        halfLane = rdWord[{reqAddr[1], 4'b0000} +: 16];
        case (reqSize)
            SIZE_BYTE: loadData = reqSigned ? {{(DATA_WIDTH-8){byteLane[7]}}, byteLane}
                                            : {{(DATA_WIDTH-8){1'b0}}, byteLane};
            SIZE_HALF: loadData = reqSigned ? {{(DATA_WIDTH-16){halfLane[15]}}, halfLane}
                                            : {{(DATA_WIDTH-16){1'b0}}, halfLane};
            default:   loadData = rdWord;
        endcase
    end

    // Memory-side outputs decode only registered state, never the live request.
    assign req_ready      = (state == IDLE);
    assign mem_read       = (state == READ);
    assign mem_write      = (state == WRITE);
    assign mem_address    = ((state == READ) || (state == WRITE)) ? {reqAddr[31:2], 2'b00} : '0;
    assign mem_write_data = (state == WRITE) ? mergedWord : '0;
    assign resp_valid     = (state == RESP);
    assign addr_error     = (state == RESP) && errFlag;
    assign resp_rdata     = ((state == RESP) && !errFlag && !reqWrite) ? loadData : '0;
    assign dbgState       = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-addressed memory model on the
// memory side; every expected value below is hand-computed.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h10010000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;
    logic [1:0]  dbgState;

    int checks = 0;
    int errors = 0;

    logic [31:0] memArr [0:1023];
    logic [31:0] offs;
    logic        memHit;
    logic [9:0]  memIdx;
    int          rdCount = 0;
    int          wrCount = 0;
    logic [31:0] lastWData = '0;
    logic [31:0] lastWAddr = '0;

    load_store_unit #(
        .DATA_WIDTH(32),
        .BASE_ADDR(32'h10010000),
        .MEMORY_DEPTH(1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .addr_error(addr_error),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .mem_read_data(mem_read_data),
        .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    always_comb begin
        offs   = mem_address - BASE;
        memHit = (mem_address >= BASE) && (offs < 32'd4096);
        memIdx = offs[11:2];
    end

    assign mem_read_data = memHit ? memArr[memIdx] : 32'h0;

    always @(posedge clk) begin
        if (mem_read) rdCount = rdCount + 1;
        if (mem_write) begin
            wrCount   = wrCount + 1;
            lastWData = mem_write_data;
            lastWAddr = mem_address;
            if (memHit) memArr[memIdx] = mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request, holds garbage on req_* while busy, and checks the response.
    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int expLat,
                       input logic [31:0] expRdata, input logic expErr,
                       input int expReads, input int expWrites);
        int n;
        int rd0;
        int wr0;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        rd0 = rdCount;
        wr0 = wrCount;
        @(posedge clk); #1;
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b1;
        req_addr   = BASE;
        req_wdata  = 32'h0BADF00D;
        check({tag, " busy"}, {31'b0, req_ready}, 32'd0);
        n = 1;
        while (!resp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(expLat));
        check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " rdata"}, resp_rdata, expRdata);
        check({tag, " addr_error"}, {31'b0, addr_error}, {31'b0, expErr});
        @(posedge clk); #1;
        check({tag, " pulse"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " reads"}, 32'(rdCount - rd0), 32'(expReads));
        check({tag, " writes"}, 32'(wrCount - wr0), 32'(expWrites));
    endtask

    initial begin
        int wr0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        #1;
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst mem_read", {31'b0, mem_read}, 32'd0);
        check("rst mem_write", {31'b0, mem_write}, 32'd0);
        check("rst mem_address", mem_address, 32'h0);
        check("rst mem_write_data", mem_write_data, 32'h0);
        check("rst addr_error", {31'b0, addr_error}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst state", {30'b0, dbgState}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // word store / load
        txn("sw deadbeef", 1'b1, 2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
        check("sw deadbeef wdata", lastWData, 32'hDEADBEEF);
        check("sw deadbeef waddr", lastWAddr, 32'h10010004);
        txn("lw deadbeef", 1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);

        // byte read-modify-write and byte loads
        txn("sw 11223344", 1'b1, 2'b10, 1'b0, 32'h10010008, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
        txn("sb aa", 1'b1, 2'b00, 1'b0, 32'h1001000A, 32'h000000AA, 3, 32'h0, 1'b0, 1, 1);
        check("sb aa wdata", lastWData, 32'h11AA3344);
        check("sb aa waddr", lastWAddr, 32'h10010008);
        txn("lb aa", 1'b0, 2'b00, 1'b1, 32'h1001000A, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 1, 0);
        txn("lbu aa", 1'b0, 2'b00, 1'b0, 32'h1001000A, 32'h0, 2, 32'h000000AA, 1'b0, 1, 0);

        // halfword loads and store
        txn("sw 80011234", 1'b1, 2'b10, 1'b0, 32'h10010008, 32'h80011234, 2, 32'h0, 1'b0, 0, 1);
        txn("lh hi", 1'b0, 2'b01, 1'b1, 32'h1001000A, 32'h0, 2, 32'hFFFF8001, 1'b0, 1, 0);
        txn("lhu hi", 1'b0, 2'b01, 1'b0, 32'h1001000A, 32'h0, 2, 32'h00008001, 1'b0, 1, 0);
        txn("lh lo", 1'b0, 2'b01, 1'b1, 32'h10010008, 32'h0, 2, 32'h00001234, 1'b0, 1, 0);
        txn("sh 5678", 1'b1, 2'b01, 1'b0, 32'h10010008, 32'hABCD5678, 3, 32'h0, 1'b0, 1, 1);
        check("sh 5678 wdata", lastWData, 32'h80015678);
        txn("lw 80015678", 1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0, 2, 32'h80015678, 1'b0, 1, 0);
        txn("sb 5a", 1'b1, 2'b00, 1'b0, 32'h10010009, 32'hFFFFFF5A, 3, 32'h0, 1'b0, 1, 1);
        check("sb 5a wdata", lastWData, 32'h80015A78);
        txn("lb 5a", 1'b0, 2'b00, 1'b1, 32'h10010009, 32'h0, 2, 32'h0000005A, 1'b0, 1, 0);

        // error cases: one-cycle response, no memory access
        txn("err lw misaligned", 1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("err lh misaligned", 1'b0, 2'b01, 1'b1, 32'h10010001, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("err size 11", 1'b0, 2'b11, 1'b0, 32'h10010000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("err below base", 1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("err sw misaligned", 1'b1, 2'b10, 1'b0, 32'h10010002, 32'hDEADBEEF, 1, 32'h0, 1'b1, 0, 0);
        txn("err sb above top", 1'b1, 2'b00, 1'b0, 32'h10011000, 32'h55, 1, 32'h0, 1'b1, 0, 0);

        // top of the data segment
        txn("sw top", 1'b1, 2'b10, 1'b0, 32'h10010FFC, 32'h12345678, 2, 32'h0, 1'b0, 0, 1);
        txn("lw top", 1'b0, 2'b10, 1'b0, 32'h10010FFC, 32'h0, 2, 32'h12345678, 1'b0, 1, 0);
        txn("lb top byte", 1'b0, 2'b00, 1'b1, 32'h10010FFF, 32'h0, 2, 32'h00000012, 1'b0, 1, 0);
        txn("err lw past top", 1'b0, 2'b10, 1'b0, 32'h10011000, 32'h0, 1, 32'h0, 1'b1, 0, 0);

        // reset in the middle of a byte store's WRITE cycle
        txn("sw cafef00d", 1'b1, 2'b10, 1'b0, 32'h10010010, 32'hCAFEF00D, 2, 32'h0, 1'b0, 0, 1);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h10010010;
        req_wdata  = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw read", {31'b0, mem_read}, 32'd1);
        @(posedge clk); #1;
        check("rmw write", {31'b0, mem_write}, 32'd1);
        check("rmw state", {30'b0, dbgState}, 32'd2);
        check("rmw addr", mem_address, 32'h10010010);
        check("rmw data", mem_write_data, 32'hCAFEF077);
        wr0 = wrCount;
        #2 reset = 1'b0;
        #1;
        check("async mem_write", {31'b0, mem_write}, 32'd0);
        check("async mem_address", mem_address, 32'h0);
        check("async mem_write_data", mem_write_data, 32'h0);
        check("async req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("post-rst writes", 32'(wrCount - wr0), 32'd0);
        check("post-rst word", memArr[4], 32'hCAFEF00D);
        check("post-rst req_ready", {31'b0, req_ready}, 32'd1);
        check("post-rst resp_valid", {31'b0, resp_valid}, 32'd0);
        txn("lw after rst", 1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0, 2, 32'hCAFEF00D, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
